// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types for the RAM bus arbiter: FSM states, grant codes
// and the byte-lane decode helper.
package ram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        GNT_HOST,
        GNT_IBUS,
        GNT_DBUS
    } gnt_t;

    // One bit of the one-hot lane decode: true when lane 'bit_idx' is
    // the lane selected by byte index 'idx'.
    function automatic logic lane_dec(input int idx, input int bit_idx);
        return idx == bit_idx;
    endfunction

endpackage

// File: rtl/ram_rr_grant.sv
// Host-priority grant with 2-way round-robin between ibus and dbus.
// Purely combinational; the rr_last register lives in the caller.
module ram_rr_grant
    import ram_bus_arbiter_pkg::*;
(
    input  logic i_host_req,
    input  logic i_ibus_req,
    input  logic i_dbus_req,
    input  gnt_t i_rr_last,
    output logic o_valid,
    output gnt_t o_gnt
);

    always_comb begin
        o_valid = i_host_req | i_ibus_req | i_dbus_req;
        o_gnt   = GNT_HOST;
        if (i_host_req) begin
            o_gnt = GNT_HOST;
        end else if (i_ibus_req && i_dbus_req) begin
            // the CPU port not served last wins a tie
            o_gnt = (i_rr_last == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;
        end else if (i_ibus_req) begin
            o_gnt = GNT_IBUS;
        end else if (i_dbus_req) begin
            o_gnt = GNT_DBUS;
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Arbitrated access sequencer sharing one single-port sync RAM between
// a host byte port, the CPU instruction bus and the CPU data bus.
module ram_bus_arbiter
    import ram_bus_arbiter_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32,
    localparam int LANES = DW / 8,
    localparam int LB = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW+LB-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             host_ack,
    input  logic             ibus_cyc,
    input  logic [31:0]      ibus_adr,
    output logic [DW-1:0]    ibus_rdt,
    output logic             ibus_ack,
    input  logic             dbus_cyc,
    input  logic [31:0]      dbus_adr,
    input  logic             dbus_we,
    input  logic [LANES-1:0] dbus_sel,
    input  logic [DW-1:0]    dbus_wdt,
    output logic [DW-1:0]    dbus_rdt,
    output logic             dbus_ack,
    output logic             ram_en,
    output logic [AW-1:0]    ram_addr,
    output logic [LANES-1:0] ram_we,
    output logic [DW-1:0]    ram_di,
    input  logic [DW-1:0]    ram_do
);

    state_t           r_state;
    state_t           w_state_nxt;
    gnt_t             r_gnt;
    gnt_t             r_rr_last;
    gnt_t             w_gnt;
    logic             w_req;
    logic [LB-1:0]    w_host_lane;
    logic [LB-1:0]    r_lane;
    logic [LANES-1:0] w_host_mask;
    logic [AW-1:0]    w_addr;
    logic [LANES-1:0] w_we;
    logic [DW-1:0]    w_di;
    logic             r_ram_en;
    logic [AW-1:0]    r_ram_addr;
    logic [LANES-1:0] r_ram_we;
    logic [DW-1:0]    r_ram_di;
    logic [7:0]       r_host_rdata;
    logic [DW-1:0]    r_ibus_rdt;
    logic [DW-1:0]    r_dbus_rdt;
    logic             r_host_ack;
    logic             r_ibus_ack;
    logic             r_dbus_ack;
    logic             w_unused;

    // CPU addresses alias modulo the RAM depth; low bits are lane selects
    assign w_unused = ^{ibus_adr[31:AW+LB], ibus_adr[LB-1:0],
                        dbus_adr[31:AW+LB], dbus_adr[LB-1:0]};

    assign w_host_lane = host_addr[LB-1:0];

    ram_rr_grant u_grant (
        .i_host_req (host_req),
        .i_ibus_req (ibus_cyc),
        .i_dbus_req (dbus_cyc),
        .i_rr_last  (r_rr_last),
        .o_valid    (w_req),
        .o_gnt      (w_gnt)
    );

    always_comb begin
        w_host_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_host_mask[i] = lane_dec(int'(w_host_lane), i);
        end
    end

    always_comb begin
        w_addr = '0;
        w_we   = '0;
        w_di   = '0;
        unique case (w_gnt)
            GNT_HOST: begin
                w_addr = host_addr[AW+LB-1:LB];
                w_we   = host_we ? w_host_mask : '0;
                w_di   = {LANES{host_wdata}};
            end
            GNT_IBUS: begin
                w_addr = ibus_adr[AW+LB-1:LB];
            end
            GNT_DBUS: begin
                w_addr = dbus_adr[AW+LB-1:LB];
                w_we   = dbus_we ? dbus_sel : '0;
                w_di   = dbus_wdt;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_req) w_state_nxt = S_ACCESS;
            S_ACCESS:  w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt        <= GNT_HOST;
            r_rr_last    <= GNT_IBUS;
            r_lane       <= '0;
            r_ram_en     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_we     <= '0;
            r_ram_di     <= '0;
            r_host_rdata <= '0;
            r_ibus_rdt   <= '0;
            r_dbus_rdt   <= '0;
            r_host_ack   <= 1'b0;
            r_ibus_ack   <= 1'b0;
            r_dbus_ack   <= 1'b0;
        end else begin
            // enable, write strobes and acks are single-cycle pulses
            r_ram_en   <= 1'b0;
            r_ram_we   <= '0;
            r_host_ack <= 1'b0;
            r_ibus_ack <= 1'b0;
            r_dbus_ack <= 1'b0;
            if (r_state == S_IDLE && w_req) begin
                r_gnt      <= w_gnt;
                r_lane     <= w_host_lane;
                r_ram_en   <= 1'b1;
                r_ram_addr <= w_addr;
                r_ram_we   <= w_we;
                r_ram_di   <= w_di;
                if (w_gnt != GNT_HOST) begin
                    r_rr_last <= w_gnt;
                end
            end
            if (r_state == S_CAPTURE) begin
                unique case (r_gnt)
                    GNT_HOST: begin
                        r_host_rdata <= ram_do[{r_lane, 3'b000} +: 8];
                        r_host_ack   <= 1'b1;
                    end
                    GNT_IBUS: begin
                        r_ibus_rdt <= ram_do;
                        r_ibus_ack <= 1'b1;
                    end
                    GNT_DBUS: begin
                        r_dbus_rdt <= ram_do;
                        r_dbus_ack <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ram_en     = r_ram_en;
    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_di     = r_ram_di;
    assign host_rdata = r_host_rdata;
    assign host_ack   = r_host_ack;
    assign ibus_rdt   = r_ibus_rdt;
    assign ibus_ack   = r_ibus_ack;
    assign dbus_rdt   = r_dbus_rdt;
    assign dbus_ack   = r_dbus_ack;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: RAM macro stand-in, transaction-level
// reference model with per-cycle compare, and directed scenarios.
module tb_ram_bus_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LANES = 4;
    localparam int LB = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             host_req;
    logic             host_we;
    logic [AW+LB-1:0] host_addr;
    logic [7:0]       host_wdata;
    logic [7:0]       host_rdata;
    logic             host_ack;
    logic             ibus_cyc;
    logic [31:0]      ibus_adr;
    logic [DW-1:0]    ibus_rdt;
    logic             ibus_ack;
    logic             dbus_cyc;
    logic [31:0]      dbus_adr;
    logic             dbus_we;
    logic [LANES-1:0] dbus_sel;
    logic [DW-1:0]    dbus_wdt;
    logic [DW-1:0]    dbus_rdt;
    logic             dbus_ack;
    logic             ram_en;
    logic [AW-1:0]    ram_addr;
    logic [LANES-1:0] ram_we;
    logic [DW-1:0]    ram_di;
    logic [DW-1:0]    ram_do = '0;

    int n_chk = 0;
    int n_pass = 0;

    ram_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .ibus_cyc   (ibus_cyc),
        .ibus_adr   (ibus_adr),
        .ibus_rdt   (ibus_rdt),
        .ibus_ack   (ibus_ack),
        .dbus_cyc   (dbus_cyc),
        .dbus_adr   (dbus_adr),
        .dbus_we    (dbus_we),
        .dbus_sel   (dbus_sel),
        .dbus_wdt   (dbus_wdt),
        .dbus_rdt   (dbus_rdt),
        .dbus_ack   (dbus_ack),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_di     (ram_di),
        .ram_do     (ram_do)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // RAM macro stand-in: read-first, per-byte write enables
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_do <= mem[ram_addr];
            for (int l = 0; l < LANES; l++)
                if (ram_we[l]) mem[ram_addr][8*l +: 8] <= ram_di[8*l +: 8];
        end
    end

    // Reference model: transaction-level view of the arbiter.
    // ph counts cycles since the grant (0 = free to grant).
    logic [31:0] ref_mem [32];
    int          ph;
    int          own;
    int          last;
    int          m_lane;
    bit          m_wr;
    logic [4:0]  m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_di;
    logic [31:0] m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0;
            own = -1;
            last = 1;
        end else if (ph == 0) begin
            own = -1;
            if (host_req) own = 0;
            else if (ibus_cyc && dbus_cyc) own = (last == 1) ? 2 : 1;
            else if (ibus_cyc) own = 1;
            else if (dbus_cyc) own = 2;
            if (own >= 0) begin
                ph = 1;
                if (own != 0) last = own;
                m_we = 4'b0;
                m_di = 32'h0;
                m_lane = 0;
                m_wr = 1'b0;
                if (own == 0) begin
                    m_addr = 5'(int'(host_addr) / 4);
                    m_lane = int'(host_addr) % 4;
                    m_wr = host_we;
                    m_we = host_we ? 4'(1 << m_lane) : 4'b0;
                    m_di = {4{host_wdata}};
                end else if (own == 1) begin
                    m_addr = 5'((ibus_adr / 4) % 32);
                end else begin
                    m_addr = 5'((dbus_adr / 4) % 32);
                    m_wr = dbus_we;
                    m_we = dbus_we ? dbus_sel : 4'b0;
                    m_di = dbus_wdt;
                end
            end
        end else if (ph == 1) begin
            m_rd = ref_mem[m_addr];
            for (int l = 0; l < 4; l++)
                if (m_we[l]) ref_mem[m_addr][8*l +: 8] = m_di[8*l +: 8];
            ph = 2;
        end else begin
            ph = (ph + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ctl", {ram_en, ram_we, host_ack, ibus_ack, dbus_ack}, 0);
            chk("rst_addr", ram_addr, 0);
            chk("rst_di", ram_di, 0);
            chk("rst_hrd", host_rdata, 0);
            chk("rst_irdt", ibus_rdt, 0);
            chk("rst_drdt", dbus_rdt, 0);
        end else begin
            chk("ram_en", ram_en, 32'(ph == 1));
            chk("ram_we", ram_we, (ph == 1) ? m_we : 4'b0);
            if (ph == 1) chk("ram_addr", ram_addr, m_addr);
            if (ph == 1 && m_we != 0) chk("ram_di", ram_di, m_di);
            chk("acks", {host_ack, ibus_ack, dbus_ack},
                (ph != 3) ? 0 : (own == 0) ? 4 : (own == 1) ? 2 : 1);
            if (ph == 3 && !m_wr) begin
                if (own == 0) chk("host_rdata", host_rdata, m_rd[8*m_lane +: 8]);
                else if (own == 1) chk("ibus_rdt", ibus_rdt, m_rd);
                else chk("dbus_rdt", dbus_rdt, m_rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic ack_of(input int w);
        case (w)
            0: return host_ack;
            1: return ibus_ack;
            default: return dbus_ack;
        endcase
    endfunction

    task automatic wait_ack(input int w, input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (ack_of(w)) got = 1'b1;
        end
        chk(nm, 32'(got), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    int order[$];
    int exp_o[4] = '{2, 1, 2, 1};
    int second;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0102_0304 + 32'(i) * 32'h1010_1010;
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        ibus_cyc = 0; ibus_adr = '0;
        dbus_cyc = 0; dbus_adr = '0; dbus_we = 0; dbus_sel = '0; dbus_wdt = '0;
        step();
        step();
        chk("reset_en", 32'(ram_en), 0);
        chk("reset_ack", {host_ack, ibus_ack, dbus_ack}, 0);
        rst_n = 1'b1;
        step();

        // host byte write, latency pinned by hand
        host_req = 1; host_we = 1; host_addr = 7'h07; host_wdata = 8'hA5;
        step();
        chk("hw_en", 32'(ram_en), 1);
        chk("hw_addr", ram_addr, 1);
        chk("hw_we", ram_we, 4'b1000);
        chk("hw_di", ram_di, 32'hA5A5_A5A5);
        step();
        step();
        chk("hw_ack_n3", 32'(host_ack), 1);
        host_req = 0;
        step();

        host_req = 1; host_we = 0; host_addr = 7'h07;
        wait_ack(0, "hr_ack");
        chk("hr_data", host_rdata, 8'hA5);
        host_req = 0;
        step();

        dbus_cyc = 1; dbus_we = 1; dbus_adr = 32'h10;
        dbus_sel = 4'b0011; dbus_wdt = 32'hDEAD_BEEF;
        wait_ack(2, "dw_ack");
        dbus_cyc = 0; dbus_we = 0;
        step();

        ibus_cyc = 1; ibus_adr = 32'h10;
        wait_ack(1, "ir_ack");
        chk("ir_merge", ibus_rdt, 32'h4142_BEEF);
        ibus_cyc = 0;
        step();

        dbus_cyc = 1; dbus_we = 1; dbus_adr = 32'h14;
        dbus_sel = 4'b0000; dbus_wdt = 32'hFFFF_FFFF;
        wait_ack(2, "dw0_ack");
        dbus_we = 0;
        step();
        wait_ack(2, "dr_ack");
        chk("dw0_keep", dbus_rdt, 32'h5152_5354);
        dbus_cyc = 0;
        step();

        ibus_cyc = 1; ibus_adr = 32'h0000_0084;
        step();
        chk("alias_addr", ram_addr, 1);
        wait_ack(1, "alias_ack");
        chk("alias_data", ibus_rdt, 32'hA512_1314);
        ibus_cyc = 0;
        step();

        host_req = 1; host_we = 0; host_addr = 7'h12;
        wait_ack(0, "hr2_ack");
        chk("hr2_data", host_rdata, 8'h42);
        host_req = 0;
        step();

        // both CPU ports held from reset
        do_reset();
        ibus_cyc = 1; ibus_adr = 32'h08;
        dbus_cyc = 1; dbus_adr = 32'h0C; dbus_we = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("rr_excl", 32'(ibus_ack && dbus_ack), 0);
            if (ibus_ack) order.push_back(1);
            if (dbus_ack) order.push_back(2);
        end
        chk("rr_count", order.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("rr_order", (k < order.size()) ? order[k] : -1, exp_o[k]);
        ibus_cyc = 0; dbus_cyc = 0;
        step();

        // host outranks both CPU ports
        host_req = 1; host_we = 0; host_addr = 7'h01;
        ibus_cyc = 1; dbus_cyc = 1;
        wait_ack(0, "prio_host");
        chk("prio_cpu_quiet", {ibus_ack, dbus_ack}, 0);
        host_req = 0;
        second = -1;
        for (int k = 0; k < 12 && second < 0; k++) begin
            step();
            if (host_ack) second = 0;
            else if (ibus_ack) second = 1;
            else if (dbus_ack) second = 2;
        end
        chk("prio_second", second, 2);
        dbus_cyc = 0;
        wait_ack(1, "prio_third");
        ibus_cyc = 0;
        step();

        // reset during the ACCESS cycle of a dbus write
        dbus_cyc = 1; dbus_we = 1; dbus_adr = 32'h18;
        dbus_sel = 4'b1111; dbus_wdt = 32'h1234_5678;
        step();
        chk("abort_in_access", 32'(ram_en), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_en", 32'(ram_en), 0);
        chk("abort_we", ram_we, 0);
        dbus_cyc = 0; dbus_we = 0;
        step();
        chk("abort_noack0", 32'(dbus_ack), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_noack", 32'(dbus_ack), 0);
        end

        ibus_cyc = 1; ibus_adr = 32'h18;
        step();
        step();
        step();
        chk("post_abort_ack", 32'(ibus_ack), 1);
        chk("post_abort_data", ibus_rdt, 32'h6162_6364);
        ibus_cyc = 0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
